// File: rtl/axi_lite_legacy_bridge_pkg.sv
// Shared types and constants for the AXI-lite to legacy chip-select bus bridge.
package axi_lite_legacy_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StResp
  } state_e;

  typedef enum logic {
    GrantRead  = 1'b0,
    GrantWrite = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_legacy_bridge_phase_timer.sv
// Phase counter shared by the SETUP/STROBE/HOLD phases; restarts at 0 on clear and saturates.
module legacy_phase_timer #(
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic             timeout
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // limit is always >= 1, so done marks the last cycle of a limit-long phase
  assign done    = (cnt_q >= (limit - CNT_W'(1)));
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/axi_lite_legacy_bridge.sv
// AXI-lite slave to legacy CS_N/WR_N/RD_N/RDY_N bus bridge, one transaction outstanding at a time.
module axi_lite_legacy_bridge
  import axi_lite_legacy_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic [ADDR_W-1:0] LEG_ADDR,
  output logic [DATA_W-1:0] LEG_DOUT,
  output logic              LEG_OE,
  input  logic [DATA_W-1:0] LEG_DIN,
  output logic              CS_N,
  output logic              WR_N,
  output logic              RD_N,
  input  logic              RDY_N,
  output logic              transaction_complete,
  output logic              error_detected
);

  localparam int unsigned CntW = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TIMEOUT_CYC <= STROBE_CYC)
  begin : g_param_check
    $error("axi_lite_legacy_bridge: timing parameters out of range");
  end

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;

  logic              cs_n_q, wr_n_q, rd_n_q, leg_oe_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [ADDR_W-1:0] leg_addr_q;
  logic [DATA_W-1:0] leg_dout_q, rdata_q;

  logic            grant_wr, grant_rd, strobe_ok, strobe_to, cs_low_d;
  logic            timer_clear, timer_done, timer_timeout;
  logic [CntW-1:0] timer_limit;

  // Round robin: with both candidates pending, the side not served last time wins
  always_comb begin
    grant_wr = (state_q == StIdle) && AWVALID && WVALID &&
               (!ARVALID || (last_grant_q == GrantRead));
    grant_rd = (state_q == StIdle) && ARVALID && !grant_wr;
  end

  assign strobe_ok = !RDY_N && timer_done;
  assign strobe_to = RDY_N && timer_timeout;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_limit  = CntW'(HOLD_CYC);
    case (state_q)
      StIdle: begin
        if (grant_wr) begin
          state_d      = StSetup;
          last_grant_d = GrantWrite;
        end else if (grant_rd) begin
          state_d      = StSetup;
          last_grant_d = GrantRead;
        end
      end
      StSetup: begin
        timer_limit = CntW'(SETUP_CYC);
        if (timer_done) state_d = StStrobe;
      end
      StStrobe: begin
        timer_limit = CntW'(STROBE_CYC);
        if (strobe_ok || strobe_to) state_d = StHold;
      end
      StHold: begin
        if (timer_done) state_d = StResp;
      end
      StResp: begin
        if ((last_grant_q == GrantWrite) ? BREADY : RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign timer_clear = (state_d != state_q);
  assign cs_low_d    = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

  legacy_phase_timer #(
    .CNT_W       (CntW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clear   (timer_clear),
    .limit   (timer_limit),
    .done    (timer_done),
    .timeout (timer_timeout)
  );

  // Bus pins are registered from next-state so they change on the same edge as the FSM
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRead;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      leg_oe_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      leg_addr_q   <= '0;
      leg_dout_q   <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cs_n_q       <= !cs_low_d;
      wr_n_q       <= !((state_d == StStrobe) && (last_grant_d == GrantWrite));
      rd_n_q       <= !((state_d == StStrobe) && (last_grant_d == GrantRead));
      leg_oe_q     <= cs_low_d && (last_grant_d == GrantWrite);
      bvalid_q     <= (state_d == StResp) && (last_grant_d == GrantWrite);
      rvalid_q     <= (state_d == StResp) && (last_grant_d == GrantRead);
      if (grant_wr) begin
        leg_addr_q <= AWADDR;
        leg_dout_q <= WDATA;
      end else if (grant_rd) begin
        leg_addr_q <= ARADDR;
      end
      if ((state_q == StStrobe) && (strobe_ok || strobe_to)) begin
        if (last_grant_q == GrantWrite) begin
          bresp_q <= strobe_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rresp_q <= strobe_ok ? RESP_OKAY : RESP_SLVERR;
          rdata_q <= strobe_ok ? LEG_DIN : '0;
        end
      end
    end
  end

  assign AWREADY  = grant_wr;
  assign WREADY   = grant_wr;
  assign ARREADY  = grant_rd;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign LEG_ADDR = leg_addr_q;
  assign LEG_DOUT = leg_dout_q;
  assign LEG_OE   = leg_oe_q;
  assign CS_N     = cs_n_q;
  assign WR_N     = wr_n_q;
  assign RD_N     = rd_n_q;

  assign transaction_complete = (bvalid_q && BREADY) || (rvalid_q && RREADY);
  assign error_detected = (bvalid_q && BREADY && (bresp_q == RESP_SLVERR)) ||
                          (rvalid_q && RREADY && (rresp_q == RESP_SLVERR));

endmodule

// File: tb/tb_axi_lite_legacy_bridge.sv
// Directed bench for axi_lite_legacy_bridge (TIMEOUT_CYC=8, other timing at defaults).
module tb_axi_lite_legacy_bridge;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, LEG_ADDR, LEG_DOUT, LEG_DIN;
  logic [1:0]  BRESP, RRESP;
  logic        LEG_OE, CS_N, WR_N, RD_N, RDY_N;
  logic        transaction_complete, error_detected;

  int total = 0;
  int bad   = 0;
  int n, rd_low, seen;

  always #5 clk_sys = ~clk_sys;

  axi_lite_legacy_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .SETUP_CYC   (1),
    .STROBE_CYC  (2),
    .HOLD_CYC    (1),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_sys              (clk_sys),
    .rst                  (rst),
    .AWVALID              (AWVALID),
    .AWREADY              (AWREADY),
    .AWADDR               (AWADDR),
    .WVALID               (WVALID),
    .WREADY               (WREADY),
    .WDATA                (WDATA),
    .BVALID               (BVALID),
    .BREADY               (BREADY),
    .BRESP                (BRESP),
    .ARVALID              (ARVALID),
    .ARREADY              (ARREADY),
    .ARADDR               (ARADDR),
    .RVALID               (RVALID),
    .RREADY               (RREADY),
    .RDATA                (RDATA),
    .RRESP                (RRESP),
    .LEG_ADDR             (LEG_ADDR),
    .LEG_DOUT             (LEG_DOUT),
    .LEG_OE               (LEG_OE),
    .LEG_DIN              (LEG_DIN),
    .CS_N                 (CS_N),
    .WR_N                 (WR_N),
    .RD_N                 (RD_N),
    .RDY_N                (RDY_N),
    .transaction_complete (transaction_complete),
    .error_detected       (error_detected)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves time 1 unit after the rising edge; checks happen one more unit later
  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = '0; WDATA = '0; ARADDR = '0; LEG_DIN = '0; RDY_N = 1'b1;
    repeat (3) next();
    #1;
    check("rst_cs_n", 32'(CS_N), 1);
    check("rst_wr_n", 32'(WR_N), 1);
    check("rst_rd_n", 32'(RD_N), 1);
    check("rst_leg_oe", 32'(LEG_OE), 0);
    check("rst_bvalid", 32'(BVALID), 0);
    check("rst_rvalid", 32'(RVALID), 0);
    check("rst_rdata", RDATA, 0);
    check("rst_leg_addr", LEG_ADDR, 0);
    rst = 1'b0;
    next();

    // Minimum-latency write
    AWVALID = 1; WVALID = 1; AWADDR = 32'h100; WDATA = 32'hDEADBEEF; RDY_N = 0; BREADY = 1;
    #1;
    check("wr_awready", 32'(AWREADY), 1);
    check("wr_wready", 32'(WREADY), 1);
    check("wr_arready", 32'(ARREADY), 0);
    next();
    AWVALID = 0; WVALID = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("wr_cs_n_t%0d", k), 32'(CS_N), (k <= 4) ? 0 : 1);
      check($sformatf("wr_wr_n_t%0d", k), 32'(WR_N), (k == 2 || k == 3) ? 0 : 1);
      check($sformatf("wr_oe_t%0d", k), 32'(LEG_OE), (k <= 4) ? 1 : 0);
      check($sformatf("wr_bvalid_t%0d", k), 32'(BVALID), (k == 5) ? 1 : 0);
      check($sformatf("wr_tc_t%0d", k), 32'(transaction_complete), (k == 5) ? 1 : 0);
      if (k == 1) begin
        check("wr_leg_addr", LEG_ADDR, 32'h100);
        check("wr_leg_dout", LEG_DOUT, 32'hDEADBEEF);
      end
      if (k == 5) check("wr_bresp", 32'(BRESP), 0);
      next();
    end
    #1;
    check("wr_bvalid_drop", 32'(BVALID), 0);
    check("wr_tc_drop", 32'(transaction_complete), 0);

    // Read with RDY_N asserted only in the 5th strobe cycle
    next();
    ARVALID = 1; ARADDR = 32'h200; LEG_DIN = 32'h12345678; RDY_N = 1; RREADY = 1;
    #1;
    check("rd_arready", 32'(ARREADY), 1);
    check("rd_awready", 32'(AWREADY), 0);
    next();
    ARVALID = 0;
    for (int k = 1; k <= 8; k++) begin
      RDY_N = (k == 6) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("rd_cs_n_t%0d", k), 32'(CS_N), (k <= 7) ? 0 : 1);
      check($sformatf("rd_rd_n_t%0d", k), 32'(RD_N), (k >= 2 && k <= 6) ? 0 : 1);
      check($sformatf("rd_rvalid_t%0d", k), 32'(RVALID), (k == 8) ? 1 : 0);
      if (k == 1) check("rd_leg_addr", LEG_ADDR, 32'h200);
      if (k == 3) check("rd_oe", 32'(LEG_OE), 0);
      if (k == 8) begin
        check("rd_rdata", RDATA, 32'h12345678);
        check("rd_rresp", 32'(RRESP), 0);
        check("rd_tc", 32'(transaction_complete), 1);
      end
      next();
    end

    // Both sides pending three times: write, read, write
    AWVALID = 1; WVALID = 1; ARVALID = 1; AWADDR = 32'h180; WDATA = 32'h0BADF00D;
    ARADDR = 32'h280; RDY_N = 0; BREADY = 1; RREADY = 1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      #1;
      while (!(AWREADY || ARREADY) && n < 30) begin
        next();
        #1;
        n++;
      end
      check($sformatf("arb_awready_%0d", g), 32'(AWREADY), (g != 1) ? 1 : 0);
      check($sformatf("arb_wready_%0d", g), 32'(WREADY), (g != 1) ? 1 : 0);
      check($sformatf("arb_arready_%0d", g), 32'(ARREADY), (g == 1) ? 1 : 0);
      if (g > 0) check($sformatf("arb_gap_%0d", g), n, 5);
      next();
    end
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    n = 0;
    #1;
    while (BVALID !== 1'b1 && n < 30) begin
      next();
      #1;
      n++;
    end
    check("arb_last_bvalid", 32'(BVALID), 1);
    next();

    // Read timeout: RDY_N never asserted
    ARVALID = 1; ARADDR = 32'h2F0; LEG_DIN = 32'hAAAA5555; RDY_N = 1; RREADY = 0;
    #1;
    check("to_arready", 32'(ARREADY), 1);
    next();
    ARVALID = 0;
    n = 0; rd_low = 0;
    #1;
    while (RVALID !== 1'b1 && n < 40) begin
      if (RD_N === 1'b0) rd_low++;
      next();
      #1;
      n++;
    end
    check("to_rvalid", 32'(RVALID), 1);
    check("to_rd_low_cycles", rd_low, 8);
    check("to_rresp", 32'(RRESP), 2);
    check("to_rdata", RDATA, 0);
    check("to_err_no_hs", 32'(error_detected), 0);
    next();
    #1;
    check("to_rvalid_held", 32'(RVALID), 1);
    check("to_rresp_held", 32'(RRESP), 2);
    RREADY = 1;
    #1;
    check("to_err_pulse", 32'(error_detected), 1);
    check("to_tc_pulse", 32'(transaction_complete), 1);
    next();
    #1;
    check("to_rvalid_drop", 32'(RVALID), 0);
    check("to_err_drop", 32'(error_detected), 0);

    // AW without W is never accepted
    next();
    AWVALID = 1; WVALID = 0; AWADDR = 32'h300; WDATA = 32'h00005A5A; RDY_N = 0; BREADY = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0 || CS_N !== 1'b1) seen++;
      next();
    end
    check("aw_only_ignored", seen, 0);
    WVALID = 1;
    #1;
    check("aw_w_awready", 32'(AWREADY), 1);
    check("aw_w_wready", 32'(WREADY), 1);
    next();
    AWVALID = 0; WVALID = 0;
    n = 0;
    #1;
    while (BVALID !== 1'b1 && n < 30) begin
      next();
      #1;
      n++;
    end
    check("aw_w_bvalid", 32'(BVALID), 1);
    check("aw_w_bresp", 32'(BRESP), 0);
    check("aw_w_leg_dout", LEG_DOUT, 32'h00005A5A);
    next();

    // Reset during the write strobe drops the transaction
    AWVALID = 1; WVALID = 1; AWADDR = 32'h400; WDATA = 32'h11112222; RDY_N = 1;
    #1;
    check("rst_mid_awready", 32'(AWREADY), 1);
    next();
    AWVALID = 0; WVALID = 0;
    n = 0;
    #1;
    while (WR_N !== 1'b0 && n < 20) begin
      next();
      #1;
      n++;
    end
    check("rst_mid_strobe", 32'(WR_N), 0);
    rst = 1'b1;
    next();
    rst = 1'b0;
    RDY_N = 0;
    #1;
    check("rst_mid_cs_n", 32'(CS_N), 1);
    check("rst_mid_wr_n", 32'(WR_N), 1);
    check("rst_mid_oe", 32'(LEG_OE), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (BVALID !== 1'b0) seen++;
      next();
      #1;
    end
    check("rst_mid_no_bvalid", seen, 0);

    // Next write after reset completes normally
    AWVALID = 1; WVALID = 1; AWADDR = 32'h500; WDATA = 32'hCAFEF00D;
    #1;
    check("post_rst_awready", 32'(AWREADY), 1);
    next();
    AWVALID = 0; WVALID = 0;
    n = 0;
    #1;
    while (BVALID !== 1'b1 && n < 30) begin
      next();
      #1;
      n++;
    end
    check("post_rst_latency", n, 4);
    check("post_rst_bvalid", 32'(BVALID), 1);
    check("post_rst_bresp", 32'(BRESP), 0);
    check("post_rst_leg_addr", LEG_ADDR, 32'h500);
    check("post_rst_leg_dout", LEG_DOUT, 32'hCAFEF00D);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
